// File: rtl/dma_read_tag_manager.sv
// dma_read_tag_manager: PCIe read-tag pool; issues DMA reads to TX and tracks completion DWs (optional timeout: DMA_RD_TAG_TIMEOUT_EN)
module dma_read_tag_manager #(
  parameter int P_TAGS     = 8,
  parameter int P_TAG_BASE = 0,
  parameter int P_TIMEOUT  = 65535
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] req_addr,
  input  logic [9:0]  req_len,
  input  logic        req_valid,
  output logic        req_done,
  output logic [7:0]  next_tag,
  output logic        tag_avail,
  output logic [31:0] tx_addr,
  output logic [9:0]  tx_len,
  output logic [7:0]  tx_tag,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        cpl_valid,
  input  logic [7:0]  cpl_tag,
  input  logic [3:0]  cpl_dwen,
  output logic        tag_release,
  output logic [7:0]  tag_release_id,
  output logic        cpl_err,
  output logic [5:0]  outstanding,
  output logic        timeout_err
);
  localparam int IW = (P_TAGS > 1) ? $clog2(P_TAGS) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_DONE} state_t;
  state_t            state_q, state_d;
  logic [P_TAGS-1:0] free_q, free_d;
  logic [10:0]       rem_q [P_TAGS];
  logic [10:0]       rem_d [P_TAGS];
  logic [IW-1:0]     nidx_q, nidx_d;
  logic [7:0]        next_tag_q, next_tag_d;
  logic [31:0]       addr_q, addr_d;
  logic [9:0]        len_q, len_d;
  logic [7:0]        tag_q, tag_d;
  logic              rel_q, rel_d;
  logic [7:0]        rel_id_q, rel_id_d;
  logic              err_q, err_d;
  logic [5:0]        outst_q, outst_d;
  logic              alloc;
  logic [9:0]        alloc_len;
  logic [8:0]        cpl_off;
  logic              cpl_in;
  logic [IW-1:0]     cpl_idx;
  logic              hit;
  logic [2:0]        dw;
`ifdef DMA_RD_TAG_TIMEOUT_EN
  logic [15:0]       tmr_q [P_TAGS];
  logic [15:0]       tmr_d [P_TAGS];
  logic              tmo_q, tmo_d;
  logic              tmo_found;
`endif

  assign cpl_off   = {1'b0, cpl_tag} - 9'(P_TAG_BASE);
  assign cpl_in    = ({1'b0, cpl_tag} >= 9'(P_TAG_BASE)) && (cpl_off < 9'(P_TAGS));
  assign cpl_idx   = cpl_off[IW-1:0];
  assign hit       = cpl_valid && cpl_in && !free_q[cpl_idx];
  assign dw        = cpl_dwen[3] ? 3'd4 : cpl_dwen[2] ? 3'd3 : cpl_dwen[1] ? 3'd2 : cpl_dwen[0] ? 3'd1 : 3'd0;
  assign alloc_len = (state_q == S_IDLE) ? req_len : len_q;
  assign tag_avail = |free_q;
  assign next_tag  = next_tag_q;
  assign tx_addr   = addr_q;
  assign tx_len    = len_q;
  assign tx_tag    = tag_q;
  assign tag_release    = rel_q;
  assign tag_release_id = rel_id_q;
  assign cpl_err        = err_q;
  assign outstanding    = outst_q;
`ifdef DMA_RD_TAG_TIMEOUT_EN
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  // request FSM: latch request, wait for a tag, present it to TX until accepted
  always_comb begin
    state_d  = state_q;
    alloc    = 1'b0;
    tx_valid = 1'b0;
    req_done = 1'b0;
    addr_d   = addr_q;
    len_d    = len_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        addr_d  = req_addr;
        len_d   = req_len;
        alloc   = tag_avail;
        state_d = tag_avail ? S_ISSUE : S_WAIT;
      end
      S_WAIT: begin
        alloc   = tag_avail;
        state_d = tag_avail ? S_ISSUE : S_WAIT;
      end
      S_ISSUE: begin
        tx_valid = 1'b1;
        state_d  = tx_ready ? S_DONE : S_ISSUE;
      end
      default: begin
        req_done = 1'b1;
        state_d  = S_IDLE;
      end
    endcase
    tag_d = alloc ? next_tag_q : tag_q;
  end

  // tag pool: completion accounting, allocation, next-tag search and occupancy
  always_comb begin
    free_d   = free_q;
    rem_d    = rem_q;
    rel_d    = 1'b0;
    rel_id_d = rel_id_q;
    err_d    = 1'b0;
    nidx_d   = '0;
    outst_d  = 6'(P_TAGS);
    if (cpl_valid && !hit) err_d = 1'b1;
    if (hit && dw != 3'd0) begin
      if ({8'd0, dw} >= rem_q[cpl_idx]) begin
        err_d            = {8'd0, dw} > rem_q[cpl_idx];
        free_d[cpl_idx]  = 1'b1;
        rem_d[cpl_idx]   = '0;
        rel_d            = 1'b1;
        rel_id_d         = cpl_tag;
      end else begin
        rem_d[cpl_idx] = rem_q[cpl_idx] - {8'd0, dw};
      end
    end
    if (alloc) begin
      free_d[nidx_q] = 1'b0;
      rem_d[nidx_q]  = (alloc_len == 10'd0) ? 11'd1024 : {1'b0, alloc_len};
    end
`ifdef DMA_RD_TAG_TIMEOUT_EN
    tmo_d     = 1'b0;
    tmo_found = 1'b0;
    for (int i = 0; i < P_TAGS; i++) begin
      tmr_d[i] = (tmr_q[i] < 16'(P_TIMEOUT)) ? tmr_q[i] + 16'd1 : tmr_q[i];
      if ((hit && cpl_idx == IW'(i)) || (alloc && nidx_q == IW'(i))) tmr_d[i] = '0;
      if (!rel_d && !tmo_found && !free_q[i] && !free_d[i] && tmr_q[i] >= 16'(P_TIMEOUT) && !(hit && cpl_idx == IW'(i))) begin
        tmo_found = 1'b1;
        free_d[i] = 1'b1;
        tmo_d     = 1'b1;
        rel_id_d  = 8'(P_TAG_BASE + i);
      end
    end
    rel_d = rel_d | tmo_d;
`endif
    for (int i = P_TAGS - 1; i >= 0; i--) if (free_d[i]) nidx_d = IW'(i);
    for (int i = 0; i < P_TAGS; i++) outst_d = outst_d - 6'(free_d[i]);
    next_tag_d = 8'(P_TAG_BASE) + 8'(nidx_d);
  end

  // state registers; reset drops every outstanding tag
  always_ff @(posedge i_clk) begin
    rem_q <= rem_d;
`ifdef DMA_RD_TAG_TIMEOUT_EN
    tmr_q <= tmr_d;
`endif
    if (i_rst) begin
      state_q    <= S_IDLE;
      free_q     <= '1;
      nidx_q     <= '0;
      next_tag_q <= 8'(P_TAG_BASE);
      addr_q     <= '0;
      len_q      <= '0;
      tag_q      <= '0;
      rel_q      <= 1'b0;
      rel_id_q   <= '0;
      err_q      <= 1'b0;
      outst_q    <= '0;
`ifdef DMA_RD_TAG_TIMEOUT_EN
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      free_q     <= free_d;
      nidx_q     <= nidx_d;
      next_tag_q <= next_tag_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      tag_q      <= tag_d;
      rel_q      <= rel_d;
      rel_id_q   <= rel_id_d;
      err_q      <= err_d;
      outst_q    <= outst_d;
`ifdef DMA_RD_TAG_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end
endmodule

// File: tb/tb_dma_read_tag_manager.sv
// tb_dma_read_tag_manager: directed self-checking bench for the read-tag manager
module tb_dma_read_tag_manager;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] req_addr = '0;
  logic [9:0]  req_len = '0;
  logic        req_valid = 1'b0;
  logic        req_done;
  logic [7:0]  next_tag;
  logic        tag_avail;
  logic [31:0] tx_addr;
  logic [9:0]  tx_len;
  logic [7:0]  tx_tag;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        cpl_valid = 1'b0;
  logic [7:0]  cpl_tag = '0;
  logic [3:0]  cpl_dwen = '0;
  logic        tag_release;
  logic [7:0]  tag_release_id;
  logic        cpl_err;
  logic [5:0]  outstanding;
  logic        timeout_err;
  int checks = 0;
  int failures = 0;
  int rel_cnt;

  dma_read_tag_manager dut (
    .i_clk(i_clk), .i_rst(i_rst), .req_addr(req_addr), .req_len(req_len), .req_valid(req_valid),
    .req_done(req_done), .next_tag(next_tag), .tag_avail(tag_avail), .tx_addr(tx_addr), .tx_len(tx_len),
    .tx_tag(tx_tag), .tx_valid(tx_valid), .tx_ready(tx_ready), .cpl_valid(cpl_valid), .cpl_tag(cpl_tag),
    .cpl_dwen(cpl_dwen), .tag_release(tag_release), .tag_release_id(tag_release_id), .cpl_err(cpl_err),
    .outstanding(outstanding), .timeout_err(timeout_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic do_req(input logic [31:0] a, input logic [9:0] l, input logic [7:0] et);
    req_valid = 1'b1; req_addr = a; req_len = l;
    tick();
    req_valid = 1'b0;
    chk("req_tx_valid", 32'(tx_valid), 32'd1);
    chk("req_tx_tag", 32'(tx_tag), 32'(et));
    chk("req_tx_len", 32'(tx_len), 32'(l));
    chk("req_tx_addr", tx_addr, a);
    tick();
    chk("req_done", 32'(req_done), 32'd1);
    tick();
  endtask

  task automatic beat(input logic [7:0] t, input logic [3:0] en);
    cpl_valid = 1'b1; cpl_tag = t; cpl_dwen = en;
    tick();
    cpl_valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    i_rst = 1'b0;
    tick();
    chk("rst_next_tag", 32'(next_tag), 32'd0);
    chk("rst_tag_avail", 32'(tag_avail), 32'd1);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_req_done", 32'(req_done), 32'd0);
    chk("rst_tag_release", 32'(tag_release), 32'd0);
    chk("rst_cpl_err", 32'(cpl_err), 32'd0);
    chk("rst_tx_tag", 32'(tx_tag), 32'd0);

    req_valid = 1'b1; req_addr = 32'h1000; req_len = 10'd4;
    tick();
    req_valid = 1'b0;
    chk("lat_tx_valid_n1", 32'(tx_valid), 32'd1);
    chk("lat_req_done_n1", 32'(req_done), 32'd0);
    chk("lat_tx_tag", 32'(tx_tag), 32'd0);
    chk("lat_tx_len", 32'(tx_len), 32'd4);
    chk("lat_tx_addr", tx_addr, 32'h1000);
    chk("lat_next_tag", 32'(next_tag), 32'd1);
    chk("lat_outstanding", 32'(outstanding), 32'd1);
    tick();
    chk("lat_req_done_n2", 32'(req_done), 32'd1);
    chk("lat_tx_valid_n2", 32'(tx_valid), 32'd0);
    tick();
    chk("lat_req_done_n3", 32'(req_done), 32'd0);

    beat(8'd0, 4'b1111);
    chk("cpl0_release", 32'(tag_release), 32'd1);
    chk("cpl0_release_id", 32'(tag_release_id), 32'd0);
    chk("cpl0_err", 32'(cpl_err), 32'd0);
    chk("cpl0_outstanding", 32'(outstanding), 32'd0);
    chk("cpl0_next_tag", 32'(next_tag), 32'd0);
    tick();
    chk("cpl0_release_pulse", 32'(tag_release), 32'd0);

    do_req(32'h2000, 10'd4, 8'd0);
    beat(8'd0, 4'b0001);
    chk("part1_release", 32'(tag_release), 32'd0);
    chk("part1_outstanding", 32'(outstanding), 32'd1);
    beat(8'd0, 4'b0000);
    chk("dw0_release", 32'(tag_release), 32'd0);
    chk("dw0_err", 32'(cpl_err), 32'd0);
    beat(8'd0, 4'b0111);
    chk("part2_release", 32'(tag_release), 32'd1);
    chk("part2_err", 32'(cpl_err), 32'd0);
    chk("part2_outstanding", 32'(outstanding), 32'd0);

    do_req(32'h3000, 10'd0, 8'd0);
    rel_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      cpl_valid = 1'b1; cpl_tag = 8'd0; cpl_dwen = 4'b1111;
      tick();
      if (k < 255) rel_cnt += int'(tag_release);
    end
    cpl_valid = 1'b0;
    chk("len1024_early_release", 32'(rel_cnt), 32'd0);
    chk("len1024_release", 32'(tag_release), 32'd1);
    chk("len1024_err", 32'(cpl_err), 32'd0);

    do_req(32'h4000, 10'd4, 8'd0);
    req_valid = 1'b1; req_addr = 32'h5000; req_len = 10'd8;
    cpl_valid = 1'b1; cpl_tag = 8'd0; cpl_dwen = 4'b1111;
    tick();
    req_valid = 1'b0; cpl_valid = 1'b0;
    chk("sim_release", 32'(tag_release), 32'd1);
    chk("sim_release_id", 32'(tag_release_id), 32'd0);
    chk("sim_tx_tag", 32'(tx_tag), 32'd1);
    chk("sim_outstanding", 32'(outstanding), 32'd1);
    tick(); tick();
    beat(8'd1, 4'b1111);
    beat(8'd1, 4'b1111);
    chk("sim_free1_err", 32'(cpl_err), 32'd0);
    chk("sim_free1_outstanding", 32'(outstanding), 32'd0);
    tick();

    for (int t = 0; t < 8; t++) do_req(32'h1_0000 + 32'(t), 10'd2, 8'(t));
    chk("full_tag_avail", 32'(tag_avail), 32'd0);
    chk("full_outstanding", 32'(outstanding), 32'd8);
    tx_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'hABCD; req_len = 10'd6;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    chk("wait_tx_valid", 32'(tx_valid), 32'd0);
    beat(8'd3, 4'b0011);
    chk("wait_release_id", 32'(tag_release_id), 32'd3);
    chk("wait_next_tag", 32'(next_tag), 32'd3);
    for (int k = 0; k < 10 && !tx_valid; k++) tick();
    chk("wait_issue_valid", 32'(tx_valid), 32'd1);
    chk("wait_issue_tag", 32'(tx_tag), 32'd3);
    chk("wait_issue_len", 32'(tx_len), 32'd6);
    tick();
    chk("hold_tx_valid", 32'(tx_valid), 32'd1);
    chk("hold_tx_tag", 32'(tx_tag), 32'd3);
    chk("hold_tx_addr", tx_addr, 32'hABCD);
    tx_ready = 1'b1;
    tick();
    chk("wait_req_done", 32'(req_done), 32'd1);
    chk("wait_outstanding", 32'(outstanding), 32'd8);
    tick();

    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("mrst_outstanding", 32'(outstanding), 32'd0);
    chk("mrst_tag_avail", 32'(tag_avail), 32'd1);
    chk("mrst_next_tag", 32'(next_tag), 32'd0);
    beat(8'd5, 4'b1111);
    chk("unalloc_err", 32'(cpl_err), 32'd1);
    chk("unalloc_release", 32'(tag_release), 32'd0);
    beat(8'd8, 4'b0001);
    chk("range_err", 32'(cpl_err), 32'd1);
    tick();
    chk("err_pulse", 32'(cpl_err), 32'd0);
    do_req(32'h6000, 10'd1, 8'd0);
    beat(8'd0, 4'b1111);
    chk("overrun_err", 32'(cpl_err), 32'd1);
    chk("overrun_outstanding", 32'(outstanding), 32'd0);
    chk("overrun_tag_avail", 32'(tag_avail), 32'd1);
    chk("overrun_next_tag", 32'(next_tag), 32'd0);
    chk("timeout_err_off", 32'(timeout_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dma_read_tag_manager.md
Name: dma_read_tag_manager

Overview:
- Sits between the DMA read request issuer (the dma_read_addr/len/valid/done/current_tag interface) and the PCIe TX request path.
- Owns the pool of PCIe read tags: publishes the next tag ahead of each request, allocates it on issue, and tracks outstanding completion DWs per tag.
- Frees a tag when its completion data is fully received, and throttles requests when no tag is free.

Parameters:
- P_TAGS, 8, number of tags in the pool (1..32).
- P_TAG_BASE, 0, value of the first tag; tags are P_TAG_BASE..P_TAG_BASE+P_TAGS-1 (8-bit).
- P_TIMEOUT, 65535, completion timeout in cycles (used only with the optional feature).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- req_addr  in  32  host address of the read request
- req_len  in  10  request length in DW (0 means 1024)
- req_valid  in  1  one-cycle request pulse
- req_done  out  1  one-cycle pulse: request handed to TX
- next_tag  out  8  tag the next accepted request will receive
- tag_avail  out  1  at least one tag is free
- tx_addr  out  32  TX request address
- tx_len  out  10  TX request length
- tx_tag  out  8  TX request tag
- tx_valid  out  1  TX request valid
- tx_ready  in  1  TX accepts request
- cpl_valid  in  1  completion data beat valid
- cpl_tag  in  8  tag of the completion beat
- cpl_dwen  in  4  DW enables of the beat: 0001=1, 001x=2, 01xx=3, 1xxx=4 DW; 0000=0 DW
- tag_release  out  1  one-cycle pulse: tag freed
- tag_release_id  out  8  tag freed
- cpl_err  out  1  one-cycle pulse: unexpected tag or DW overrun
- outstanding  out  6  number of allocated tags
- timeout_err  out  1  one-cycle pulse: tag timed out (0 when feature is absent)

Behaviour:
- Reset: all tags free; FSM in IDLE. tx_valid, req_done, tag_release, cpl_err and timeout_err are 0; outstanding=0; next_tag=P_TAG_BASE; tag_avail=1; tx_addr/tx_len/tx_tag/tag_release_id=0.
- A reset mid-operation discards every outstanding tag. Completions arriving after reset for old tags raise cpl_err.
- Free vector: P_TAGS bits. next_tag = lowest-index free tag, registered, updated every cycle. tag_avail = |free.
- FSM states:
  - IDLE: on req_valid, latch req_addr/req_len. If tag_avail, go to ISSUE and allocate next_tag (clear its free bit, load remaining[tag] = len==0 ? 1024 : len, 11 bits); else go to WAIT.
  - WAIT: allocate once tag_avail, then go to ISSUE.
  - ISSUE: tx_valid=1 with the latched addr/len and allocated tag. All TX outputs stay stable until tx_ready. On tx_valid&&tx_ready go to DONE.
  - DONE: req_done=1 for one cycle, then go to IDLE.
- req_valid outside IDLE is ignored; the upstream issuer does not send one before req_done.
- Latency with a tag free and tx_ready held high: req_valid at cycle N gives tx_valid at N+1 and req_done at N+2.
- Completion beat, when cpl_tag is in range and allocated:
  - remaining -= DW(cpl_dwen).
  - When the result is 0: set the free bit and pulse tag_release/tag_release_id on the next cycle.
  - If DW > remaining: cpl_err pulse, and the tag is freed.
  - cpl_dwen=0000: no change.
- cpl_tag out of range or not allocated: cpl_err pulse; beat ignored.
- Simultaneous allocate and release:
  - Both take effect in the same cycle.
  - outstanding is unchanged.
  - A tag freed in cycle N is not allocatable before N+1.
- outstanding = P_TAGS - popcount(free), registered.

Optional Feature:
- Macro DMA_RD_TAG_TIMEOUT_EN.
- Defined:
  - A per-tag 16-bit cycle timer is cleared at allocation and at every beat for that tag.
  - When a timer reaches P_TIMEOUT, the tag is freed and timeout_err + tag_release pulse together with tag_release_id = that tag.
  - If two tags time out in the same cycle, the lowest index goes first and the other one the next cycle.
- Undefined: no timers; timeout_err is tied to 0; a lost completion holds its tag until reset.

Test Plan:
- Reset, P_TAGS=8, P_TAG_BASE=0: next_tag=0, tag_avail=1, outstanding=0, tx_valid=0.
- req_valid (addr=0x1000, len=4), tx_ready=1: tx_valid at N+1 with tx_tag=0, tx_len=4; req_done at N+2; next_tag=1; outstanding=1.
- Completion tag 0 with dwen 1111: tag_release with id 0 on the next cycle; outstanding=0; next_tag=0.
- Issue 8 requests with no completions: tag_avail=0. 9th req_valid parks in WAIT. Complete tag 3 (len=2, dwen 0011): 9th request issues with tx_tag=3.
- Completion for unallocated tag 5, then an overrun on tag 0 (len=1, dwen 1111): cpl_err pulses twice; tag 0 freed.
- With DMA_RD_TAG_TIMEOUT_EN and P_TIMEOUT=100: allocate tag 0, send no completion -> timeout_err + tag_release with id 0 after 100 cycles.
